// File: rtl/spi_slave_burst.sv
// Multi-drop SPI slave: decodes ID/address/rw/burst command, then moves DATA_W-bit words on a register bus.
// Define SPI_SLV_ERR_CNT_EN to add the saturating aborted-frame counter err_cnt.
module spi_slave_burst #(
  parameter int         DATA_W = 16,
  parameter int         ADDR_W = 8,
  parameter logic [2:0] MY_ID  = 3'd0,
  parameter bit         CPOL   = 1'b0,
  parameter bit         CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
`ifdef SPI_SLV_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CMD_W = ADDR_W + 8;
  localparam int MAXW  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int SH_W  = MAXW - 1;
  localparam int CNT_W = $clog2(MAXW);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CMD, SKIP, WDATA, RDATA} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              burst;
  logic              rd_dly;
  logic              sclk_p0, sclk_p1, sclk_p2;
  logic              cs_p0, cs_p1;
  logic              mosi_p0, mosi_p1;
  logic [SH_W-1:0]   sh_in;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shift_out;
  logic              lead_edge, trail_edge, sample_edge, shift_edge;
  logic [DATA_W-1:0] data_next;

  // p0/p1: two-flop synchronisers; p2: previous synchronised sclk for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= CPOL;
      sclk_p1 <= CPOL;
      sclk_p2 <= CPOL;
      cs_p0   <= 1'b1;
      cs_p1   <= 1'b1;
      mosi_p0 <= 1'b0;
      mosi_p1 <= 1'b0;
    end else begin
      sclk_p0 <= sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      cs_p0   <= cs_n;
      cs_p1   <= cs_p0;
      mosi_p0 <= mosi;
      mosi_p1 <= mosi_p0;
    end
  end

  assign lead_edge   = (sclk_p2 == CPOL) && (sclk_p1 != CPOL);
  assign trail_edge  = (sclk_p2 != CPOL) && (sclk_p1 == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;

  // sh_in holds all but the bit arriving on this sample edge, so command fields sit one bit lower
  assign data_next = {sh_in[DATA_W-2:0], mosi_p1};
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      burst     <= 1'b0;
      rd_dly    <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      rd_dly <= reg_rd;
      if (cs_p1 && state != IDLE) begin
        state   <= IDLE;
        cnt     <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!cs_p1) begin
            cnt   <= '0;
            state <= CMD;
          end
          CMD: if (sample_edge) begin
            if (cnt == CMD_LAST) begin
              cnt <= '0;
              if (sh_in[CMD_W-2 -: 3] != MY_ID) begin
                state <= SKIP;
              end else begin
                reg_addr <= sh_in[ADDR_W+1:2];
                burst    <= sh_in[1];
                if (sh_in[0]) begin
                  reg_rd  <= 1'b1;
                  miso_oe <= 1'b1;
                  state   <= RDATA;
                end else begin
                  state <= WDATA;
                end
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WDATA: begin
            // advance the burst address only after the strobe has used it
            if (reg_wr && burst) reg_addr <= reg_addr + 1'b1;
            if (sample_edge) begin
              if (cnt == DATA_LAST) begin
                cnt       <= '0;
                reg_wr    <= 1'b1;
                reg_wdata <= data_next;
                if (!burst) state <= SKIP;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          RDATA: begin
            if (shift_edge) miso <= (cnt == '0) ? hold[DATA_W-1] : shift_out[DATA_W-1];
            if (sample_edge) begin
              if (cnt == DATA_LAST) begin
                cnt <= '0;
                if (burst) begin
                  reg_addr <= reg_addr + 1'b1;
                  reg_rd   <= 1'b1;
                end else begin
                  state   <= SKIP;
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // hold is refilled the clk after each reg_rd and consumed at the next word's first shift edge
  always_ff @(posedge clk) begin
    if (sample_edge) sh_in <= {sh_in[SH_W-2:0], mosi_p1};
    if (rd_dly) hold <= reg_rdata;
    if (state == RDATA && shift_edge)
      shift_out <= (cnt == '0) ? {hold[DATA_W-2:0], 1'b0} : {shift_out[DATA_W-2:0], 1'b0};
  end

`ifdef SPI_SLV_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cs_p1 && cnt != '0 && (state == CMD || state == WDATA || state == RDATA) &&
                 err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
